// File: rtl/msf_pkg.sv
// Shared types and slot map for the MSF frame decoder: lock state, voted-slot
// indices and the per-second result decode.
package msf_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } state_e;

    localparam int SLOT_START      = 0;
    localparam int SLOT_A          = 1;
    localparam int SLOT_B          = 2;
    localparam int SLOT_M0         = 3;
    localparam int SLOT_M1         = 4;
    localparam int NUM_VOTED_SLOTS = 5;

    // Returns {second_00, A, B, error}; data is forced to 00 on a minute marker.
    function automatic logic [3:0] decode_second(input logic [NUM_VOTED_SLOTS-1:0] v);
        logic       s00;
        logic [1:0] data;
        logic       err;
        s00  = &v;
        data = s00 ? 2'b00 : {v[SLOT_A], v[SLOT_B]};
        err  = !v[SLOT_START] | (v[SLOT_M0] != v[SLOT_M1])
             | (v[SLOT_M0] & v[SLOT_M1] & !s00);
        return {s00, data, err};
    endfunction

endpackage

// File: rtl/msf_slot_voter.sv
// Counts carrier-off samples across one slot; vote_o already includes the
// sample presented this cycle so the caller can latch it on the slot's last sample.
module msf_slot_voter #(
    parameter int SLOT_LEN    = 10,
    parameter int VOTE_THRESH = SLOT_LEN / 2 + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic data_i,
    output logic vote_o
);

    localparam int CW = $clog2(SLOT_LEN + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d  = (clr_i ? '0 : cnt_q) + {{(CW-1){1'b0}}, data_i};
        vote_o = (32'(cnt_d) >= VOTE_THRESH);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/msf_frame_decoder.sv
// MSF second decoder: locks to the once-per-second carrier-off edge, votes
// slots 0-4 with a shared voter and reports A/B, minute marker and framing error.
module msf_frame_decoder
    import msf_pkg::*;
#(
    parameter int SAMPLES_PER_SEC = 100,
    parameter int SLOT_LEN        = SAMPLES_PER_SEC / 10,
    parameter int VOTE_THRESH     = SLOT_LEN / 2 + 1,
    parameter int TOL_SAMPLES     = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sample_valid_i,
    input  logic       sample_data_i,
    output logic       bits_valid_o,
    output logic       bits_is_second_00_o,
    output logic [1:0] bits_data_o,
    output logic       bits_error_o,
    output logic       sync_o
);

    localparam int IW = $clog2(SAMPLES_PER_SEC + TOL_SAMPLES + 1);
    localparam int PW = $clog2(SLOT_LEN);
    localparam logic [IW-1:0] WIN_LO   = IW'(SAMPLES_PER_SEC - TOL_SAMPLES);
    localparam logic [IW-1:0] WIN_HI   = IW'(SAMPLES_PER_SEC + TOL_SAMPLES);
    localparam logic [PW-1:0] POS_LAST = PW'(SLOT_LEN - 1);

    state_e                       state_q;
    logic                         prev_q;
    logic [IW-1:0]                idx_q;
    logic [PW-1:0]                pos_q;
    logic [3:0]                   slot_q;
    logic [NUM_VOTED_SLOTS-1:0]   votes_q;
    logic                         bits_valid_q;
    logic                         s00_q;
    logic [1:0]                   data_q;
    logic                         err_q;

    logic                         is_edge, restart, timeout, advance, fire;
    logic                         slot_clr, slot_last, slot_vote;
    logic [IW-1:0]                idx_d;
    logic [PW-1:0]                pos_d;
    logic [3:0]                   slot_d;
    logic [NUM_VOTED_SLOTS-1:0]   votes_d;
    logic [3:0]                   result;

    // idx_d/pos_d/slot_d describe the incoming sample's position in the second.
    always_comb begin
        is_edge = sample_data_i & ~prev_q;
        idx_d   = idx_q + 1'b1;
        restart = is_edge & ((state_q == HUNT) | ((idx_d >= WIN_LO) & (idx_d <= WIN_HI)));
        timeout = (state_q == FRAME) & ~restart & (idx_d == WIN_HI);
        advance = (state_q == FRAME) & ~restart & ~timeout;

        if (restart) begin
            pos_d  = '0;
            slot_d = '0;
        end else if (pos_q == POS_LAST) begin
            pos_d  = '0;
            slot_d = slot_q + 4'd1;
        end else begin
            pos_d  = pos_q + 1'b1;
            slot_d = slot_q;
        end

        slot_clr  = (pos_d == '0);
        slot_last = (pos_d == POS_LAST);

        votes_d = restart ? '0 : votes_q;
        if (slot_last && (slot_d < 4'(NUM_VOTED_SLOTS))) begin
            votes_d[slot_d[2:0]] = slot_vote;
        end
        fire   = sample_valid_i & (restart | advance) & slot_last
               & (slot_d == 4'(SLOT_M1));
        result = decode_second(votes_d);
    end

    msf_slot_voter #(
        .SLOT_LEN    (SLOT_LEN),
        .VOTE_THRESH (VOTE_THRESH)
    ) u_voter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (sample_valid_i & (restart | advance)),
        .clr_i  (slot_clr),
        .data_i (sample_data_i),
        .vote_o (slot_vote)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= HUNT;
            prev_q       <= 1'b1;
            idx_q        <= '0;
            pos_q        <= '0;
            slot_q       <= '0;
            votes_q      <= '0;
            bits_valid_q <= 1'b0;
            s00_q        <= 1'b0;
            data_q       <= 2'b00;
            err_q        <= 1'b0;
        end else begin
            bits_valid_q <= 1'b0;
            if (sample_valid_i) begin
                prev_q <= sample_data_i;
                if (restart) begin
                    state_q <= FRAME;
                    idx_q   <= '0;
                end else if (timeout) begin
                    state_q <= HUNT;
                end else if (advance) begin
                    idx_q <= idx_d;
                end
                if (restart || advance) begin
                    pos_q   <= pos_d;
                    slot_q  <= slot_d;
                    votes_q <= votes_d;
                end
                if (fire) begin
                    bits_valid_q <= 1'b1;
                    s00_q        <= result[3];
                    data_q       <= result[2:1];
                    err_q        <= result[0];
                end
            end
        end
    end

    assign bits_valid_o        = bits_valid_q;
    assign bits_is_second_00_o = s00_q;
    assign bits_data_o         = data_q;
    assign bits_error_o        = err_q;
    assign sync_o              = (state_q == FRAME);

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Bench for msf_frame_decoder: directed seconds plus randomized noisy seconds,
// checked against a per-sample behavioural model of the MSF framing rules.
module tb_msf_frame_decoder;

    localparam int SPS = 100;
    localparam int TOL = 5;
    localparam int SL  = SPS / 10;
    localparam int THR = SL / 2 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic       sample_data = 1'b0;
    logic       bits_valid, bits_s00, bits_err, sync;
    logic [1:0] bits_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_locked = 1'b0;
    bit         m_prev = 1'b1;
    int         m_k = 0;
    int         m_cnt [5];
    bit         exp_pulse = 1'b0;
    bit         exp_s00 = 1'b0;
    bit         exp_err = 1'b0;
    bit   [1:0] exp_data = 2'b00;

    always #5 clk = ~clk;

    msf_frame_decoder #(
        .SAMPLES_PER_SEC (SPS),
        .TOL_SAMPLES     (TOL)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .sample_valid_i      (sample_valid),
        .sample_data_i       (sample_data),
        .bits_valid_o        (bits_valid),
        .bits_is_second_00_o (bits_s00),
        .bits_data_o         (bits_data),
        .bits_error_o        (bits_err),
        .sync_o              (sync)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("sync", 8'(sync), 8'(m_locked));
        chk("pulse", 8'(bits_valid), 8'(exp_pulse));
        chk("data", 8'(bits_data), 8'(exp_data));
        chk("second_00", 8'(bits_s00), 8'(exp_s00));
        chk("error", 8'(bits_err), 8'(exp_err));
    endtask

    task automatic model_expect_result();
        bit [4:0] v;
        for (int i = 0; i < 5; i++) v[i] = (m_cnt[i] >= THR);
        exp_s00   = &v;
        exp_data  = exp_s00 ? 2'b00 : {v[1], v[2]};
        exp_err   = !v[0] || (v[3] != v[4]) || (v[3] && v[4] && !exp_s00);
        exp_pulse = 1'b1;
    endtask

    task automatic model_step(input bit d);
        bit is_edge;
        int n;
        is_edge   = d && !m_prev;
        m_prev    = d;
        exp_pulse = 1'b0;
        n         = m_k + 1;
        if (is_edge && (!m_locked || (n >= SPS - TOL && n <= SPS + TOL))) begin
            m_locked = 1'b1;
            m_k      = 0;
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_cnt[0] = 1;
        end else if (m_locked && n == SPS + TOL) begin
            m_locked = 1'b0;
        end else if (m_locked) begin
            m_k = n;
            if (n < 5 * SL) m_cnt[n / SL] += int'(d);
            if (n == 5 * SL - 1) model_expect_result();
        end
    endtask

    task automatic send(input bit d);
        sample_valid = 1'b1;
        sample_data  = d;
        model_step(d);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int cnt, input bit d);
        for (int i = 0; i < cnt; i++) send(d);
    endtask

    task automatic idle(input int cnt);
        sample_valid = 1'b0;
        exp_pulse    = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
    endtask

    // One full second: slot k carries v[k] with up to nflip samples forced the other way.
    task automatic send_second(input bit [4:0] v, input int nflip, input bit gaps);
        bit b [SPS];
        int p;
        for (int i = 0; i < SPS; i++) b[i] = (i < 5 * SL) ? v[i / SL] : 1'b0;
        b[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < nflip; j++) begin
                p = $urandom_range(SL - 1, (k == 0) ? 1 : 0);
                b[k * SL + p] = ~v[k];
            end
        end
        for (int i = 0; i < SPS; i++) begin
            send(b[i]);
            if (gaps && ($urandom_range(7, 0) == 0)) idle($urandom_range(3, 1));
        end
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        rst          = 1'b1;
        #1;
        m_locked  = 1'b0;
        m_prev    = 1'b1;
        m_k       = 0;
        exp_pulse = 1'b0;
        exp_s00   = 1'b0;
        exp_err   = 1'b0;
        exp_data  = 2'b00;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Normal second: 20 off, 80 on -> A=1, B=0
        run(30, 1'b0);
        run(20, 1'b1);
        run(80, 1'b0);
        chk("t1_data", 8'(bits_data), 8'h2);

        // Minute marker then a plain 00 second
        run(50, 1'b1);
        run(50, 1'b0);
        chk("t2_s00", 8'(bits_s00), 8'h1);
        run(10, 1'b1);
        run(90, 1'b0);
        chk("t2_s00_next", 8'(bits_s00), 8'h0);

        // Noise in the A slot: 6 of 10 off votes 1, 5 of 10 votes 0
        run(10, 1'b1); run(4, 1'b0); run(6, 1'b1); run(80, 1'b0);
        chk("t3_a_set", 8'(bits_data), 8'h2);
        run(10, 1'b1); run(5, 1'b0); run(5, 1'b1); run(80, 1'b0);
        chk("t3_a_clr", 8'(bits_data), 8'h0);

        // Loss of lock after a good second, then reacquire
        send_second(5'b00011, 0, 1'b0);
        run(120, 1'b0);
        chk("t4_unlocked", 8'(sync), 8'h0);
        send_second(5'b00101, 0, 1'b0);
        run(1, 1'b1);
        run(99, 1'b0);

        // B-slot edge ignored, in-window edge at idx 97 restarts
        run(10, 1'b1); run(10, 1'b0); run(10, 1'b1); run(20, 1'b0);
        run(47, 1'b0);
        send_second(5'b00011, 0, 1'b0);

        // Valid gap mid-second leaves framing untouched
        run(10, 1'b1); run(21, 1'b0);
        idle(1000);
        run(19, 1'b0);
        run(50, 1'b0);

        // Reset mid-frame: no pulse for the interrupted second, then reacquire
        run(10, 1'b1); run(21, 1'b0);
        do_reset();
        run(69, 1'b0);
        send_second(5'b11111, 0, 1'b0);

        // Randomized seconds with noise and valid gaps
        for (int s = 0; s < 12; s++) begin
            send_second(5'($urandom_range(31, 0)) | 5'b00001, $urandom_range(4, 0), 1'b1);
        end
        run(10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
